// File: rtl/ami_req_arbiter_pkg.sv
// AOSF1Types: arbiter defaults, request payload layout and quiesce state encoding.
package AOSF1Types;
    localparam int F1_NUM_APPS        = 8;
    localparam int F1_AMI_ARB_MAX_OUT = 16;
    localparam int F1_AMI_ARB_ADDR_W  = 64;
    localparam int F1_AMI_ARB_SIZE_W  = 31;
    localparam int F1_AMI_ARB_WR_W    = 1;
    localparam int F1_AMI_ARB_REQ_W   = F1_AMI_ARB_ADDR_W + F1_AMI_ARB_SIZE_W + F1_AMI_ARB_WR_W;

    typedef struct packed {
        logic [F1_AMI_ARB_ADDR_W-1:0] addr;
        logic [F1_AMI_ARB_SIZE_W-1:0] size;
        logic [F1_AMI_ARB_WR_W-1:0]   wr;
    } ami_req_t;

    typedef enum logic [1:0] {Q_RUN, Q_DRAIN, Q_QUIET} qstate_e;
endpackage

// File: rtl/ami_req_arbiter_if.sv
// ami_req_arbiter_if: app/memory handshake bundle; AMI_ARB_PERF_EN adds perf_sel/perf_cnt.
interface ami_req_arbiter_if
    import AOSF1Types::*;
#(
    parameter int NUM_APPS = F1_NUM_APPS,
    parameter int REQ_W    = F1_AMI_ARB_REQ_W
);
    localparam int IW = $clog2(NUM_APPS);
    logic [NUM_APPS-1:0]       app_req_valid;
    logic [NUM_APPS*REQ_W-1:0] app_req_data;
    logic [NUM_APPS-1:0]       app_req_ready;
    logic                      mem_req_valid;
    logic [REQ_W-1:0]          mem_req_data;
    logic [IW-1:0]             mem_req_app_id;
    logic                      mem_req_ready;
    logic                      mem_resp_done;
    logic [IW-1:0]             mem_resp_app_id;
    logic [NUM_APPS-1:0]       quiesce_req;
    logic [NUM_APPS-1:0]       quiesce_ack;
    logic                      err_underflow;
`ifdef AMI_ARB_PERF_EN
    logic [IW-1:0]             perf_sel;
    logic [31:0]               perf_cnt;
`endif

    modport master (
`ifdef AMI_ARB_PERF_EN
        input  perf_sel,
        output perf_cnt,
`endif
        input  app_req_valid, app_req_data, mem_req_ready, mem_resp_done, mem_resp_app_id, quiesce_req,
        output app_req_ready, mem_req_valid, mem_req_data, mem_req_app_id, quiesce_ack, err_underflow
    );

    modport slave (
`ifdef AMI_ARB_PERF_EN
        output perf_sel,
        input  perf_cnt,
`endif
        output app_req_valid, app_req_data, mem_req_ready, mem_resp_done, mem_resp_app_id, quiesce_req,
        input  app_req_ready, mem_req_valid, mem_req_data, mem_req_app_id, quiesce_ack, err_underflow
    );
endinterface

// File: rtl/ami_req_arbiter_rr_pick.sv
// rr_pick: round-robin pick of the first eligible bit at or after the pointer, wrapping.
module rr_pick #(
    parameter int N  = 8,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  elig_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);
    logic [N-1:0] hi, pick;

    // Prefer candidates at or above the pointer; fall back to the wrapped set.
    assign hi    = elig_i & ~((N'(1) << ptr_i) - N'(1));
    assign pick  = |hi ? hi : elig_i;
    assign gnt_o = pick & (~pick + N'(1));
    assign any_o = |elig_i;

    always_comb begin
        idx_o = '0;
        for (int k = 0; k < N; k++) if (gnt_o[k]) idx_o = IW'(k);
    end
endmodule

// File: rtl/ami_req_arbiter.sv
// ami_req_arbiter: round-robin N-app request arbiter with outstanding limits and quiesce; AMI_ARB_PERF_EN adds grant counters.
module ami_req_arbiter
    import AOSF1Types::*;
#(
    parameter int NUM_APPS = F1_NUM_APPS,
    parameter int REQ_W    = F1_AMI_ARB_REQ_W,
    parameter int MAX_OUT  = F1_AMI_ARB_MAX_OUT
) (
    input logic clk,
    input logic rst_n,
    ami_req_arbiter_if.master bus
);
    localparam int IW = $clog2(NUM_APPS);
    localparam int CW = $clog2(MAX_OUT + 1);

    logic                mem_valid_q, mem_valid_d;
    logic [REQ_W-1:0]    mem_data_q, mem_data_d;
    logic [IW-1:0]       mem_id_q, mem_id_d;
    logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
    logic                err_q, err_d;
    logic [CW-1:0]       out_cnt_q [NUM_APPS];
    logic [CW-1:0]       out_cnt_d [NUM_APPS];
    qstate_e             q_state_q [NUM_APPS];
    qstate_e             q_state_d [NUM_APPS];
    logic [NUM_APPS-1:0] held, elig, gnt, ready_v, inc, dec, ack;
    logic [IW-1:0]       gnt_idx;
    logic                gnt_any, free, acc, do_gnt;

    assign free   = ~mem_valid_q | bus.mem_req_ready;
    assign acc    = mem_valid_q & bus.mem_req_ready;
    assign do_gnt = gnt_any & free;

    // The held request counts against the limit so out_cnt can never pass MAX_OUT.
    always_comb begin
        held = '0;
        elig = '0;
        inc  = '0;
        dec  = '0;
        for (int i = 0; i < NUM_APPS; i++) begin
            held[i] = mem_valid_q && (mem_id_q == IW'(i));
            elig[i] = bus.app_req_valid[i] & ~bus.quiesce_req[i] & ((out_cnt_q[i] + CW'(held[i])) < CW'(MAX_OUT));
            inc[i]  = acc && (mem_id_q == IW'(i));
            dec[i]  = bus.mem_resp_done && (bus.mem_resp_app_id == IW'(i));
        end
    end

    rr_pick #(.N(NUM_APPS), .IW(IW)) u_pick (
        .elig_i (elig),
        .ptr_i  (rr_ptr_q),
        .gnt_o  (gnt),
        .idx_o  (gnt_idx),
        .any_o  (gnt_any)
    );

    assign ready_v = (do_gnt && rst_n) ? gnt : '0;

    always_comb begin
        mem_valid_d = do_gnt | (mem_valid_q & ~bus.mem_req_ready);
        mem_data_d  = do_gnt ? bus.app_req_data[gnt_idx*REQ_W +: REQ_W] : mem_data_q;
        mem_id_d    = do_gnt ? gnt_idx : mem_id_q;
        rr_ptr_d    = !do_gnt ? rr_ptr_q : (gnt_idx == IW'(NUM_APPS - 1)) ? '0 : gnt_idx + 1'b1;
        err_d       = err_q;
        for (int i = 0; i < NUM_APPS; i++) begin
            out_cnt_d[i] = (inc[i] == dec[i]) ? out_cnt_q[i] :
                           inc[i] ? out_cnt_q[i] + 1'b1 :
                           (out_cnt_q[i] != '0) ? out_cnt_q[i] - 1'b1 : out_cnt_q[i];
            err_d = err_d | (dec[i] & ~inc[i] & (out_cnt_q[i] == '0));
        end
    end

    // Drain completes on next-cycle values so the ack shows right after the last response.
    always_comb begin
        ack = '0;
        for (int i = 0; i < NUM_APPS; i++) begin
            q_state_d[i] = q_state_q[i];
            ack[i]       = q_state_q[i] == Q_QUIET;
            unique case (q_state_q[i])
                Q_RUN:   q_state_d[i] = bus.quiesce_req[i] ? Q_DRAIN : Q_RUN;
                Q_DRAIN: q_state_d[i] = (out_cnt_d[i] == '0 && !(mem_valid_d && mem_id_d == IW'(i))) ? Q_QUIET : Q_DRAIN;
                Q_QUIET: q_state_d[i] = bus.quiesce_req[i] ? Q_QUIET : Q_RUN;
                default: q_state_d[i] = Q_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_valid_q <= 1'b0;
            mem_data_q  <= '0;
            mem_id_q    <= '0;
            rr_ptr_q    <= '0;
            err_q       <= 1'b0;
            out_cnt_q   <= '{default: '0};
            q_state_q   <= '{default: Q_RUN};
        end else begin
            mem_valid_q <= mem_valid_d;
            mem_data_q  <= mem_data_d;
            mem_id_q    <= mem_id_d;
            rr_ptr_q    <= rr_ptr_d;
            err_q       <= err_d;
            out_cnt_q   <= out_cnt_d;
            q_state_q   <= q_state_d;
        end
    end

    assign bus.app_req_ready  = ready_v;
    assign bus.mem_req_valid  = mem_valid_q;
    assign bus.mem_req_data   = mem_data_q;
    assign bus.mem_req_app_id = mem_id_q;
    assign bus.quiesce_ack    = ack;
    assign bus.err_underflow  = err_q;

`ifdef AMI_ARB_PERF_EN
    logic [31:0] perf_q [NUM_APPS];
    logic [31:0] perf_out_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q     <= '{default: '0};
            perf_out_q <= '0;
        end else begin
            for (int i = 0; i < NUM_APPS; i++)
                if (ready_v[i] && perf_q[i] != '1) perf_q[i] <= perf_q[i] + 1'b1;
            perf_out_q <= perf_q[bus.perf_sel];
        end
    end

    assign bus.perf_cnt = perf_out_q;
`endif
endmodule
